// File: rtl/multicycle_controller.sv
// Control unit for the multi-cycle MIPS core: Moore main-decoder FSM plus
// combinational ALU decoder driving the datapath selects and write enables.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       memtoreg,
   output logic       regdst,
   output logic       iord,
   output logic [1:0] pcsrc,
   output logic [1:0] alusrcb,
   output logic       alusrca,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       pcen,
   output logic [2:0] alucontrol,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRd    = 4'd3,
      StMemWb    = 4'd4,
      StMemWr    = 4'd5,
      StExecute  = 4'd6,
      StAluWb    = 4'd7,
      StBranch   = 4'd8,
      StAddiExec = 4'd9,
      StAddiWb   = 4'd10,
      StJump     = 4'd11
   } state_e;

   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpJ     = 6'b000010;

   state_e     state_q, state_d;
   logic [1:0] aluop;
   logic       pcwrite;
   logic       branch;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = StFetch;
      memtoreg = 1'b0;
      regdst   = 1'b0;
      iord     = 1'b0;
      pcsrc    = 2'b00;
      alusrcb  = 2'b00;
      alusrca  = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
      aluop    = 2'b00;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      case (state_q)
         StFetch: begin
            alusrcb = 2'b01;
            irwrite = 1'b1;
            pcwrite = 1'b1;
            state_d = StDecode;
         end
         StDecode: begin
            alusrcb = 2'b11;
            case (opcode)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StExecute;
               OpBeq:      state_d = StBranch;
               OpAddi:     state_d = StAddiExec;
               OpJ:        state_d = StJump;
               default: begin
                  state_d = StFetch;
                  illegal = 1'b1;
               end
            endcase
         end
         StMemAdr: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (opcode == OpLw) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            iord    = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
         end
         StMemWr: begin
            iord     = 1'b1;
            memwrite = 1'b1;
         end
         StExecute: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = StAluWb;
         end
         StAluWb: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
         end
         StBranch: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         StAddiExec: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = StAddiWb;
         end
         StAddiWb: begin
            regwrite = 1'b1;
         end
         StJump: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: ;
      endcase

      // Reset holds every control quiet, even before the state register clears.
      if (!reset) begin
         memtoreg = 1'b0;
         regdst   = 1'b0;
         iord     = 1'b0;
         pcsrc    = 2'b00;
         alusrcb  = 2'b00;
         alusrca  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         illegal  = 1'b0;
      end
   end

   always_comb begin
      alucontrol = 3'b010;
      case (aluop)
         2'b01: alucontrol = 3'b110;
         2'b10: begin
            case (funct)
               6'b100010: alucontrol = 3'b110;
               6'b100100: alucontrol = 3'b000;
               6'b100101: alucontrol = 3'b001;
               6'b101010: alucontrol = 3'b111;
               default:   alucontrol = 3'b010;
            endcase
         end
         default: alucontrol = 3'b010;
      endcase
      if (!reset) begin
         alucontrol = 3'b000;
      end
   end

   assign pcen  = reset & (pcwrite | (branch & zero));
   assign state = reset ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected output
// vectors are queued when an instruction is driven and popped each cycle.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       memtoreg, regdst, iord, alusrca, irwrite, memwrite, regwrite, pcen, illegal;
   logic [1:0] pcsrc, alusrcb;
   logic [2:0] alucontrol;
   logic [3:0] state;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [19:0] v;
      string       tag;
   } exp_t;

   exp_t exp_q[$];

   multicycle_controller dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .memtoreg   (memtoreg),
      .regdst     (regdst),
      .iord       (iord),
      .pcsrc      (pcsrc),
      .alusrcb    (alusrcb),
      .alusrca    (alusrca),
      .irwrite    (irwrite),
      .memwrite   (memwrite),
      .regwrite   (regwrite),
      .pcen       (pcen),
      .alucontrol (alucontrol),
      .state      (state),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   // Expected outputs for one state, written straight from the state table.
   function automatic logic [19:0] model(input logic [3:0] st, input logic [5:0] op,
                                         input logic [5:0] fn, input logic z);
      logic       mtr, rd, io, asa, irw, mw, rw, pcw, br, ill;
      logic [1:0] ps, asb, aop;
      logic [2:0] ac;
      mtr = 0; rd = 0; io = 0; asa = 0; irw = 0; mw = 0; rw = 0; pcw = 0; br = 0; ill = 0;
      ps = 2'b00; asb = 2'b00; aop = 2'b00;
      case (st)
         4'd0:  begin asb = 2'b01; irw = 1; pcw = 1; end
         4'd1:  begin
            asb = 2'b11;
            ill = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                               6'b000010});
         end
         4'd2:  begin asa = 1; asb = 2'b10; end
         4'd3:  io = 1;
         4'd4:  begin mtr = 1; rw = 1; end
         4'd5:  begin io = 1; mw = 1; end
         4'd6:  begin asa = 1; aop = 2'b10; end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin asa = 1; aop = 2'b01; ps = 2'b01; br = 1; end
         4'd9:  begin asa = 1; asb = 2'b10; end
         4'd10: rw = 1;
         4'd11: begin ps = 2'b10; pcw = 1; end
         default: ;
      endcase
      if (aop == 2'b01) ac = 3'b110;
      else if (aop == 2'b10) begin
         case (fn)
            6'b100000: ac = 3'b010;
            6'b100010: ac = 3'b110;
            6'b100100: ac = 3'b000;
            6'b100101: ac = 3'b001;
            6'b101010: ac = 3'b111;
            default:   ac = 3'b010;
         endcase
      end else ac = 3'b010;
      return {st, mtr, rd, io, ps, asb, asa, irw, mw, rw, pcw | (br & z), ac, ill};
   endfunction

   task automatic push(input logic [19:0] v, input string tag);
      exp_t e;
      e.v   = v;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic check_pop();
      exp_t        e;
      logic [19:0] obs;
      obs = {state, memtoreg, regdst, iord, pcsrc, alusrcb, alusrca, irwrite, memwrite,
             regwrite, pcen, alucontrol, illegal};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
         end
      end
   endtask

   // seq holds state codes, first state in the low nibble.
   task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                            input logic z, input logic [23:0] seq, input int n);
      opcode = op;
      funct  = fn;
      zero   = z;
      for (int i = 0; i < n; i++) begin
         push(model(seq[4*i +: 4], op, fn, z), $sformatf("%s_c%0d", name, i));
      end
      for (int i = 0; i < n; i++) begin
         check_pop();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset  = 1'b0;
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      zero   = 1'($urandom);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         opcode = 6'($urandom);
         zero   = 1'($urandom);
         push(20'h0, $sformatf("reset_hold_%0d", i));
         check_pop();
      end
      reset = 1'b1;
      #1;

      run_instr("lw",       6'b100011, 6'b000000, 1'b0, 24'h043210, 5);
      run_instr("sw",       6'b101011, 6'b000000, 1'b1, 24'h005210, 4);
      run_instr("r_sub",    6'b000000, 6'b100010, 1'b0, 24'h007610, 4);
      run_instr("r_slt",    6'b000000, 6'b101010, 1'b0, 24'h007610, 4);
      run_instr("r_and",    6'b000000, 6'b100100, 1'b1, 24'h007610, 4);
      run_instr("r_or",     6'b000000, 6'b100101, 1'b0, 24'h007610, 4);
      run_instr("r_add",    6'b000000, 6'b100000, 1'b0, 24'h007610, 4);
      run_instr("r_badfn",  6'b000000, 6'b111111, 1'b0, 24'h007610, 4);
      run_instr("beq_z1",   6'b000100, 6'b100101, 1'b1, 24'h000810, 3);
      run_instr("beq_z0",   6'b000100, 6'b100101, 1'b0, 24'h000810, 3);
      run_instr("addi",     6'b001000, 6'b101010, 1'b1, 24'h00a910, 4);
      run_instr("j",        6'b000010, 6'b000000, 1'b1, 24'h000b10, 3);
      run_instr("illegal",  6'b111111, 6'b000000, 1'b1, 24'h000010, 2);
      run_instr("illegal2", 6'b000011, 6'b100010, 1'b0, 24'h000010, 2);

      // Abort a load in MEMRD with reset.
      run_instr("lw_abort", 6'b100011, 6'b000000, 1'b0, 24'h000210, 3);
      push(model(4'd3, 6'b100011, 6'b000000, 1'b0), "lw_abort_memrd");
      check_pop();
      reset = 1'b0;
      #1;
      push(20'h0, "abort_reset_asserted");
      check_pop();
      @(posedge clk);
      #1;
      push(20'h0, "abort_reset_edge");
      check_pop();
      reset = 1'b1;
      #1;
      run_instr("after_abort_sw", 6'b101011, 6'b000000, 1'b0, 24'h005210, 4);

      push(model(4'd0, 6'b000000, 6'b000000, 1'b0), "final_fetch");
      opcode = 6'b000000;
      funct  = 6'b000000;
      zero   = 1'b0;
      check_pop();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
